// File: rtl/dds_monitor.sv
// Measures the period and peak excursions of a signed sample stream using hysteretic rising crossings.
// Latency: 1 cycle from the accepted crossing sample to registered period/peak_max/peak_min and meas_valid.
// Backpressure: none; sample_valid only qualifies input cycles, and unqualified cycles leave all state untouched.
`timescale 1ns/1ps
module dds_monitor #(
  parameter int OUT_W = 14,
  parameter int CNT_W = 24,
  parameter int HYST  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [OUT_W-1:0] sample_in,
  input  logic                    sample_valid,
  output logic [CNT_W-1:0]        period,
  output logic signed [OUT_W-1:0] peak_max,
  output logic signed [OUT_W-1:0] peak_min,
  output logic                    meas_valid,
  output logic                    locked,
  output logic                    timeout
);

  typedef enum logic [1:0] {INIT_LOW, INIT_HIGH, RUN_LOW, RUN_HIGH} state_t;

  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [OUT_W:0]   HYST_POS = $signed((OUT_W+1)'(HYST));
  localparam logic signed [OUT_W:0]   HYST_NEG = -HYST_POS;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic signed [OUT_W-1:0] run_max, run_min, run_max_nxt, run_min_nxt;
  logic signed [OUT_W-1:0] upd_max, upd_min;
  logic signed [OUT_W:0]   sample_ext;
  logic                    low_evt, high_evt;
  logic                    capture, to_fire;

  // Threshold compares one bit wider so -HYST never wraps at the most negative sample.
  assign sample_ext = {sample_in[OUT_W-1], sample_in};
  assign low_evt    = sample_valid && (sample_ext <= HYST_NEG);
  assign high_evt   = sample_valid && (sample_ext >= HYST_POS);
  assign upd_max    = (sample_in > run_max) ? sample_in : run_max;
  assign upd_min    = (sample_in < run_min) ? sample_in : run_min;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT_LOW;
    else     state <= state_nxt;
  end

  // Next state, counter/tracker updates and capture/timeout strobes; idle cycles hold everything
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    run_max_nxt = run_max;
    run_min_nxt = run_min;
    capture     = 1'b0;
    to_fire     = 1'b0;
    if (sample_valid) begin
      case (state)
        INIT_LOW: begin
          if (low_evt) state_nxt = INIT_HIGH;
        end
        INIT_HIGH: begin
          // First rising crossing only opens the measurement window
          if (high_evt) begin
            state_nxt   = RUN_LOW;
            cnt_nxt     = CNT_ONE;
            run_max_nxt = sample_in;
            run_min_nxt = sample_in;
          end
        end
        RUN_LOW, RUN_HIGH: begin
          if (state == RUN_HIGH && high_evt) begin
            // Crossing beats saturation; the crossing sample starts the next window
            capture     = 1'b1;
            state_nxt   = RUN_LOW;
            cnt_nxt     = CNT_ONE;
            run_max_nxt = sample_in;
            run_min_nxt = sample_in;
          end else if (cnt == CNT_MAX) begin
            to_fire     = 1'b1;
            state_nxt   = INIT_LOW;
            cnt_nxt     = '0;
            run_max_nxt = '0;
            run_min_nxt = '0;
          end else begin
            cnt_nxt     = cnt + CNT_ONE;
            run_max_nxt = upd_max;
            run_min_nxt = upd_min;
            if (state == RUN_LOW && low_evt) state_nxt = RUN_HIGH;
          end
        end
        default: state_nxt = INIT_LOW;
      endcase
    end
  end

  // Running period counter and peak trackers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      run_max <= '0;
      run_min <= '0;
    end else begin
      cnt     <= cnt_nxt;
      run_max <= run_max_nxt;
      run_min <= run_min_nxt;
    end
  end

  // Registered results: captured on a crossing, held otherwise; strobes last one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period     <= '0;
      peak_max   <= '0;
      peak_min   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= capture;
      timeout    <= to_fire;
      if (capture) begin
        period   <= cnt;
        peak_max <= run_max;
        peak_min <= run_min;
        locked   <= 1'b1;
      end else if (to_fire) begin
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_monitor.sv
// Self-checking bench for dds_monitor: hand table, directed multi-cycle sequences, random vs reference model.
// Latency: outputs compared 1 ns after each rising edge against model/table values for that edge.
// Backpressure: none; the bench drives sample_valid patterns directly.
`timescale 1ns/1ps
module tb_dds_monitor;
  localparam int OUT_W = 14;
  localparam int CNT_W = 8;
  localparam int HYST  = 64;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [OUT_W-1:0] sample_in;
  logic                    sample_valid;
  logic [CNT_W-1:0]        period;
  logic signed [OUT_W-1:0] peak_max, peak_min;
  logic                    meas_valid, locked, timeout;

  dds_monitor #(.OUT_W(OUT_W), .CNT_W(CNT_W), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .period(period), .peak_max(peak_max), .peak_min(peak_min),
    .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 waits for a low, 1 waits for the first high, 2 measures.
  // The current window is kept as a list of samples; its length is the period.
  int m_mode;
  bit m_armed;
  int m_q[$];
  int m_period, m_max, m_min;
  bit m_meas, m_locked, m_to;

  task automatic model_reset();
    m_mode = 0; m_armed = 0; m_q.delete();
    m_period = 0; m_max = 0; m_min = 0;
    m_meas = 0; m_locked = 0; m_to = 0;
  endtask

  task automatic model_step(input bit v, input int x);
    bit lo, hi;
    m_meas = 0; m_to = 0;
    if (!v) return;
    lo = (x <= -HYST);
    hi = (x >= HYST);
    if (m_mode == 0) begin
      if (lo) m_mode = 1;
    end else if (m_mode == 1) begin
      if (hi) begin m_mode = 2; m_armed = 0; m_q.delete(); m_q.push_back(x); end
    end else begin
      if (m_armed && hi) begin
        m_period = m_q.size();
        m_max = m_q[0]; m_min = m_q[0];
        foreach (m_q[i]) begin
          if (m_q[i] > m_max) m_max = m_q[i];
          if (m_q[i] < m_min) m_min = m_q[i];
        end
        m_meas = 1; m_locked = 1; m_armed = 0;
        m_q.delete(); m_q.push_back(x);
      end else if (m_q.size() == CMAX) begin
        m_to = 1; m_locked = 0; m_mode = 0; m_q.delete();
      end else begin
        m_q.push_back(x);
        if (lo) m_armed = 1;
      end
    end
  endtask

  task automatic expect_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    expect_int({nm, ".period"},   period,     m_period);
    expect_int({nm, ".peak_max"}, peak_max,   m_max);
    expect_int({nm, ".peak_min"}, peak_min,   m_min);
    expect_int({nm, ".meas"},     meas_valid, m_meas);
    expect_int({nm, ".locked"},   locked,     m_locked);
    expect_int({nm, ".timeout"},  timeout,    m_to);
  endtask

  task automatic check_zero(input string nm);
    expect_int({nm, ".period"},   period,     0);
    expect_int({nm, ".peak_max"}, peak_max,   0);
    expect_int({nm, ".peak_min"}, peak_min,   0);
    expect_int({nm, ".meas"},     meas_valid, 0);
    expect_int({nm, ".locked"},   locked,     0);
    expect_int({nm, ".timeout"},  timeout,    0);
  endtask

  // Drive one cycle, advance the model on the edge, leave time at edge+1ns for checking
  task automatic step(input bit v, input int x);
    sample_valid = v;
    sample_in    = OUT_W'(x);
    @(posedge clk);
    model_step(v, x);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_zero("reset");
    rst = 1'b0;
  endtask

  // Ten-sample sine, 8191 * sin(36 deg * k), rounded
  function automatic int sine_at(input int k);
    case (k % 10)
      0: return 0;     1: return 4815;  2: return 7790;  3: return 7790;  4: return 4815;
      5: return 0;     6: return -4815; 7: return -7790; 8: return -7790; default: return -4815;
    endcase
  endfunction

  typedef struct {
    bit v; int x; int per; int pmax; int pmin; bit mv; bit lk; bit to;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int first, last, cnt_m, cnt_t, k, at_to;
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    model_reset();
    #1 check_zero("async_reset");

    // Hysteresis boundaries, init sequence, idle cycle, two measurements
    tbl[0]  = '{1'b1,  -63, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1,   64, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1,  -64, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1,   63, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1,   64, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1,  100, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1,  -63, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, -500, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1,  -64, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, -200, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1,   63, 0,   0,    0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1,   64, 6, 100, -200, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1,    0, 6, 100, -200, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1,  -64, 6, 100, -200, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1,   64, 3,  64,  -64, 1'b1, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].x);
      expect_int($sformatf("tbl%0d.period", i),   period,     tbl[i].per);
      expect_int($sformatf("tbl%0d.peak_max", i), peak_max,   tbl[i].pmax);
      expect_int($sformatf("tbl%0d.peak_min", i), peak_min,   tbl[i].pmin);
      expect_int($sformatf("tbl%0d.meas", i),     meas_valid, tbl[i].mv);
      expect_int($sformatf("tbl%0d.locked", i),   locked,     tbl[i].lk);
      expect_int($sformatf("tbl%0d.timeout", i),  timeout,    tbl[i].to);
    end

    // Crossing exactly at saturation wins, then timeout from RUN_HIGH
    do_reset();
    step(1, -100); step(1, 100); step(1, -100);
    for (int i = 0; i < CMAX - 2; i++) step(1, 0);
    step(1, 100);
    expect_int("satx.period", period, CMAX);
    expect_int("satx.meas", meas_valid, 1);
    expect_int("satx.timeout", timeout, 0);
    check_model("satx");
    step(1, -100);
    for (int i = 0; i < CMAX - 2; i++) step(1, 0);
    step(1, 0);
    expect_int("sat_hi.timeout", timeout, 1);
    expect_int("sat_hi.locked", locked, 0);
    expect_int("sat_hi.period", period, CMAX);
    check_model("sat_hi");
    step(1, 0);
    expect_int("sat_hi.pulse", timeout, 0);

    // Continuous sine: first pulse on sample 21, then every 10
    do_reset();
    first = -1; last = -1; cnt_m = 0;
    for (int i = 0; i < 80; i++) begin
      step(1, sine_at(i));
      check_model("sine");
      if (meas_valid) begin
        if (first < 0) first = i;
        else expect_int("sine.spacing", i - last, 10);
        last = i; cnt_m++;
        expect_int("sine.period", period, 10);
        expect_int("sine.peak_max", peak_max, 7790);
        expect_int("sine.peak_min", peak_min, -7790);
      end
    end
    expect_int("sine.first", first, 21);
    expect_int("sine.count", cnt_m, 6);
    expect_int("sine.locked", locked, 1);

    // Sine with valid toggling: period unchanged, pulses every 20 cycles
    do_reset();
    first = -1; last = -1; cnt_m = 0; k = 0;
    for (int i = 0; i < 160; i++) begin
      if (i % 2 == 0) begin step(1, sine_at(k)); k++; end
      else step(0, int'($urandom_range(0, 16383)) - 8192);
      check_model("sine_tog");
      if (meas_valid) begin
        if (first >= 0) expect_int("sine_tog.spacing", i - last, 20);
        if (first < 0) first = i;
        last = i; cnt_m++;
        expect_int("sine_tog.period", period, 10);
      end
    end
    expect_int("sine_tog.count", cnt_m, 6);

    // Square +/-1000 with in-band glitches in the low half
    do_reset();
    first = -1; cnt_m = 0;
    for (int i = 0; i < 120; i++) begin
      k = i % 20;
      step(1, (k == 13) ? 30 : (k == 16) ? 63 : (k < 10) ? 1000 : -1000);
      check_model("square");
      if (meas_valid) begin
        if (first < 0) first = i;
        cnt_m++;
        expect_int("square.period", period, 20);
      end
    end
    expect_int("square.first", first, 40);
    expect_int("square.count", cnt_m, 4);

    // Constant +500 after lock: one more crossing, then saturation timeout
    cnt_m = 0; cnt_t = 0; at_to = -1;
    for (int j = 0; j < 270; j++) begin
      step(1, 500);
      check_model("const");
      if (meas_valid) cnt_m++;
      if (timeout) begin cnt_t++; at_to = j; end
      expect_int("const.excl", int'(meas_valid & timeout), 0);
    end
    expect_int("const.meas_count", cnt_m, 1);
    expect_int("const.to_count", cnt_t, 1);
    expect_int("const.to_index", at_to, CMAX);
    expect_int("const.locked", locked, 0);
    expect_int("const.period", period, 20);

    // Reset mid-period, asserted between edges
    do_reset();
    for (int i = 0; i < 25; i++) step(1, sine_at(i));
    expect_int("midrst.pre_locked", locked, 1);
    #2 rst = 1'b1;
    #1 check_zero("midrst.async");
    sample_valid = 1'b1; sample_in = 14'sd7000;
    @(posedge clk); @(posedge clk); #1;
    check_zero("midrst.held");
    model_reset();
    rst = 1'b0;
    first = -1; cnt_m = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, sine_at(25 + i));
      check_model("midrst");
      if (meas_valid) begin
        if (first < 0) first = i;
        cnt_m++;
        expect_int("midrst.period", period, 10);
      end
    end
    expect_int("midrst.first", first, 16);
    expect_int("midrst.count", cnt_m, 4);

    // Random stimulus against the model, with long in-band runs to reach saturation
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r, x;
      bit v;
      if (i % 600 == 599) do_reset();
      if (i % 500 == 250) begin
        for (int j = 0; j < 300; j++) begin
          step(1, int'($urandom_range(0, 126)) - 63);
          check_model("rnd_band");
        end
      end
      v = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 9));
      if (r == 0)      x = ($urandom_range(0, 1) != 0) ? HYST : -HYST;
      else if (r == 1) x = ($urandom_range(0, 1) != 0) ? HYST - 1 : -(HYST - 1);
      else if (r < 6)  x = int'($urandom_range(0, 16383)) - 8192;
      else             x = int'($urandom_range(0, 126)) - 63;
      step(v, x);
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
